ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Registered, sequenced control unit for the 9-bit ISA. It decodes one instruction per cycle into a pipeline register of control signals for reg_file, ALU, data_memory and the program counter. It adds behaviour a purely combinational decoder cannot provide:
- a start/idle gate,
- multi-cycle load waits with a stall back to fetch,
- sticky halt/Ack and illegal-opcode reporting,
- parametrised register-address width and memory latency.

It sits between instruction ROM/fetch and the datapath in top_level.

## Interface
Reset is asynchronous and active-low, named `Reset` to match the codebase's port naming. `Reset` = 0 clears the block; this is opposite to the existing blocks.

Parameters:
- RW, 4: register address width; 3-bit instruction fields are zero-extended to RW; RW ≥ 4.
- MEM_LAT, 2: load latency in cycles, range 0..7.

Ports:
- Clk  in  1  clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  leave IDLE.
- InstValid  in  1  Instruction is valid this cycle.
- Instruction  in  9  machine code.
- Stall  out  1  fetch must hold PC/Instruction.
- CtrlValid  out  1  registered control bundle is valid.
- RegWrEn, MemWrEn, MemRdEn  out  1 each  write/read enables.
- JumpEqual, JumpNotEqual, OffsetEn  out  1 each  to PC.
- PCRegSelect  out  2  PC register select.
- WriteSource  out  3  000 ALU, 001 mem, 010 lLUT, 011 mLUT, 100 imm.
- ALUOp  out  3  definitions ALU op code.
- ReadRegAddrA, ReadRegAddrB, WriteRegAddr  out  RW each  register addresses.
- ImmOut  out  8  {3'b0, Instruction[4:0]}.
- Ack  out  1  program done; sticky.
- IllegalOp  out  1  sticky illegal-opcode flag.
- Busy  out  1  state ≠ IDLE and state ≠ HALT.

## Operation
States: IDLE, RUN, MEMWAIT, HALT.

Transitions:
- IDLE → RUN on Start.
- RUN: accepts an instruction when InstValid = 1 (Stall is always 0 in RUN).
- RUN → MEMWAIT on an accepted load with MEM_LAT ≥ 1.
- MEMWAIT → RUN after MEM_LAT cycles.
- RUN → HALT on an accepted 9'h1FF. HALT exits only by reset.

Decode, by priority:
- 9'h1FF: halt. Takes priority over mov.
- [8:6] = 000 / 001: lsl / lsr. Write [5:3]; A = r8; B = [2:0]; ALUOp kLSH / kRSH.
- [8:5] = 1101: or. Write = A = [4:2]; B = {1,[1:0]}; kORR.
- [8:5] = 0110: xor. Write = A = [4:2]; B = r8; kXOR.
- [8:5] = 0111: rxr. Write = A = [4:2]; kRXR.
- [8:5] = 1110: add/sub. As xor; kADD if [1] = 0, else kSUB.
- [8:5] = 1111: mov. Write r8; WriteSource 100.
- [8:5] = 1000: je/jne. PCRegSelect = [3:2]; [4] selects JumpNotEqual.
- [8:5] = 1001: spc. PCRegSelect = [4:3]; OffsetEn = [2].
- [8:5] = 1010: lut. Write r8; [1] = 0: WriteSource 010, A = [4:2]; [1] = 1: WriteSource 011, B = [4:2].
- [8:4] = 01000: load. Write [3:1]; A = r8; WriteSource 001.
- [8:4] = 01001: store. MemWrEn; A = r8; B = [3:1].
- Anything else: NOP. CtrlValid = 1, all enables 0, IllegalOp set.

Unused address/ALUOp fields are 0, never latched garbage.

Bubbles: in RUN with InstValid = 0, and in IDLE, CtrlValid and all enables are 0 and address fields hold their previous values.

Halt: Ack = 1 from the cycle after acceptance. All enables 0, Stall = 1, Start ignored.

Reset values: all outputs 0; state IDLE; IllegalOp 0.

## Timing
- Non-load latency: instruction accepted at edge k → control bundle valid during cycle k+1. Throughput 1 instruction/cycle.
- Stall is a combinational decode of state: 1 in MEMWAIT and HALT, 0 in IDLE and RUN.
- Load with MEM_LAT = L ≥ 1:
  - Cycles k+1..k+L: MemRdEn = 1, CtrlValid = 0, RegWrEn = 0, Stall = 1. Addresses stay stable.
  - Cycle k+L+1: CtrlValid = 1, RegWrEn = 1, MemRdEn = 0, Stall = 0. A new instruction may be accepted at the end of this cycle.
- Load with MEM_LAT = 0: MemRdEn and RegWrEn assert together in cycle k+1, with no stall.
- Wait counter is $clog2(MEM_LAT+1) bits and loads MEM_LAT-1 on entry to MEMWAIT.
- Reset asserted mid-MEMWAIT clears all outputs immediately; no write enable may glitch high.

## Structure
- Package `definitions` gains:
  - a state enum `ctrl_state_t`;
  - WriteSource constants kSRC_ALU, kSRC_MEM, kSRC_LLUT, kSRC_MLUT, kSRC_IMM;
  - opcode match constants;
  - a packed struct `ctrl_bundle_t` holding all control outputs.
- Sub-module `ctrl_decode`: combinational, Instruction → `ctrl_bundle_t` plus illegal/halt/load flags.
- `ctrl_seq` itself holds the FSM, the wait counter and the bundle register.

## Test plan
- Reset, then Start, then 9'b1110_010_00 (add r2 += r8) → next cycle: CtrlValid = 1, RegWrEn = 1, WriteRegAddr = 2, ReadRegAddrB = 8, ALUOp = kADD.
- MEM_LAT = 2, load 9'b01000_011_0 → 2 cycles with Stall = 1 and MemRdEn = 1, then RegWrEn = 1, WriteRegAddr = 3, WriteSource = 001, Stall = 0.
- Back-to-back store then je with InstValid held high → two consecutive valid bundles: MemWrEn = 1, then JumpEqual = 1 with the correct PCRegSelect.
- 9'h1FF → Ack = 1 and Stall = 1; later Start and valid instructions leave all enables 0.
- Opcode 9'b1100_00000 → IllegalOp = 1 (sticky), all enables 0, CtrlValid = 1.
- Reset driven low during MEMWAIT → all outputs 0 immediately; after release, state is IDLE and Busy = 0.

Source files
------------

// File: rtl/definitions.sv
// Shared types and constants for the 9-bit ISA control path: FSM states,
// WriteSource and ALU op encodings, opcode match values and the control bundle.
package definitions;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        MEMWAIT = 2'd2,
        HALT    = 2'd3
    } ctrl_state_t;

    localparam logic [2:0] kADD = 3'd0;
    localparam logic [2:0] kLSH = 3'd1;
    localparam logic [2:0] kRSH = 3'd2;
    localparam logic [2:0] kSUB = 3'd3;
    localparam logic [2:0] kXOR = 3'd4;
    localparam logic [2:0] kORR = 3'd5;
    localparam logic [2:0] kRXR = 3'd6;

    localparam logic [2:0] kSRC_ALU  = 3'b000;
    localparam logic [2:0] kSRC_MEM  = 3'b001;
    localparam logic [2:0] kSRC_LLUT = 3'b010;
    localparam logic [2:0] kSRC_MLUT = 3'b011;
    localparam logic [2:0] kSRC_IMM  = 3'b100;

    localparam logic [8:0] kOP_HALT   = 9'h1FF;
    localparam logic [2:0] kOP_LSL    = 3'b000;
    localparam logic [2:0] kOP_LSR    = 3'b001;
    localparam logic [3:0] kOP_OR     = 4'b1101;
    localparam logic [3:0] kOP_XOR    = 4'b0110;
    localparam logic [3:0] kOP_RXR    = 4'b0111;
    localparam logic [3:0] kOP_ADDSUB = 4'b1110;
    localparam logic [3:0] kOP_MOV    = 4'b1111;
    localparam logic [3:0] kOP_JMP    = 4'b1000;
    localparam logic [3:0] kOP_SPC    = 4'b1001;
    localparam logic [3:0] kOP_LUT    = 4'b1010;
    localparam logic [4:0] kOP_LOAD   = 5'b01000;
    localparam logic [4:0] kOP_STORE  = 5'b01001;

    // Decoded register numbers never exceed r8, so 4 bits carry them; the
    // top zero-extends to the configured address width.
    localparam logic [3:0] kR8 = 4'd8;

    typedef struct packed {
        logic       ctrl_valid;
        logic       reg_wr_en;
        logic       mem_wr_en;
        logic       mem_rd_en;
        logic       jump_equal;
        logic       jump_not_equal;
        logic       offset_en;
        logic [1:0] pc_reg_select;
        logic [2:0] write_source;
        logic [2:0] alu_op;
        logic [3:0] rd_addr_a;
        logic [3:0] rd_addr_b;
        logic [3:0] wr_addr;
        logic [7:0] imm;
    } ctrl_bundle_t;

    function automatic logic [3:0] reg_field(input logic [2:0] f);
        return {1'b0, f};
    endfunction

    // A bubble keeps addresses and selects, dropping validity and every enable.
    function automatic ctrl_bundle_t bubble(input ctrl_bundle_t b);
        ctrl_bundle_t r;
        r                = b;
        r.ctrl_valid     = 1'b0;
        r.reg_wr_en      = 1'b0;
        r.mem_wr_en      = 1'b0;
        r.mem_rd_en      = 1'b0;
        r.jump_equal     = 1'b0;
        r.jump_not_equal = 1'b0;
        r.offset_en      = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: maps one 9-bit instruction to a control
// bundle plus halt / load / illegal flags for the sequencer.
module ctrl_decode
    import definitions::*;
(
    input  logic [8:0]   Instruction,
    output ctrl_bundle_t bundle,
    output logic         is_illegal,
    output logic         is_halt,
    output logic         is_load
);

    always_comb begin
        bundle              = '0;
        bundle.ctrl_valid   = 1'b1;
        bundle.write_source = kSRC_ALU;
        bundle.imm          = {3'b000, Instruction[4:0]};
        is_illegal          = 1'b0;
        is_halt             = 1'b0;
        is_load             = 1'b0;

        // Halt is checked first so it shadows the mov encoding it falls inside.
        if (Instruction == kOP_HALT) begin
            is_halt           = 1'b1;
            bundle.ctrl_valid = 1'b0;
        end else if (Instruction[8:6] == kOP_LSL || Instruction[8:6] == kOP_LSR) begin
            bundle.reg_wr_en = 1'b1;
            bundle.wr_addr   = reg_field(Instruction[5:3]);
            bundle.rd_addr_a = kR8;
            bundle.rd_addr_b = reg_field(Instruction[2:0]);
            bundle.alu_op    = Instruction[6] ? kRSH : kLSH;
        end else if (Instruction[8:5] == kOP_OR) begin
            bundle.reg_wr_en = 1'b1;
            bundle.wr_addr   = reg_field(Instruction[4:2]);
            bundle.rd_addr_a = reg_field(Instruction[4:2]);
            bundle.rd_addr_b = reg_field({1'b1, Instruction[1:0]});
            bundle.alu_op    = kORR;
        end else if (Instruction[8:5] == kOP_XOR) begin
            bundle.reg_wr_en = 1'b1;
            bundle.wr_addr   = reg_field(Instruction[4:2]);
            bundle.rd_addr_a = reg_field(Instruction[4:2]);
            bundle.rd_addr_b = kR8;
            bundle.alu_op    = kXOR;
        end else if (Instruction[8:5] == kOP_RXR) begin
            bundle.reg_wr_en = 1'b1;
            bundle.wr_addr   = reg_field(Instruction[4:2]);
            bundle.rd_addr_a = reg_field(Instruction[4:2]);
            bundle.alu_op    = kRXR;
        end else if (Instruction[8:5] == kOP_ADDSUB) begin
            bundle.reg_wr_en = 1'b1;
            bundle.wr_addr   = reg_field(Instruction[4:2]);
            bundle.rd_addr_a = reg_field(Instruction[4:2]);
            bundle.rd_addr_b = kR8;
            bundle.alu_op    = Instruction[1] ? kSUB : kADD;
        end else if (Instruction[8:5] == kOP_MOV) begin
            bundle.reg_wr_en    = 1'b1;
            bundle.wr_addr      = kR8;
            bundle.write_source = kSRC_IMM;
        end else if (Instruction[8:5] == kOP_JMP) begin
            bundle.pc_reg_select  = Instruction[3:2];
            bundle.jump_equal     = ~Instruction[4];
            bundle.jump_not_equal = Instruction[4];
        end else if (Instruction[8:5] == kOP_SPC) begin
            bundle.pc_reg_select = Instruction[4:3];
            bundle.offset_en     = Instruction[2];
        end else if (Instruction[8:5] == kOP_LUT) begin
            bundle.reg_wr_en = 1'b1;
            bundle.wr_addr   = kR8;
            if (Instruction[1]) begin
                bundle.write_source = kSRC_MLUT;
                bundle.rd_addr_b    = reg_field(Instruction[4:2]);
            end else begin
                bundle.write_source = kSRC_LLUT;
                bundle.rd_addr_a    = reg_field(Instruction[4:2]);
            end
        end else if (Instruction[8:4] == kOP_LOAD) begin
            is_load             = 1'b1;
            bundle.reg_wr_en    = 1'b1;
            bundle.mem_rd_en    = 1'b1;
            bundle.wr_addr      = reg_field(Instruction[3:1]);
            bundle.rd_addr_a    = kR8;
            bundle.write_source = kSRC_MEM;
        end else if (Instruction[8:4] == kOP_STORE) begin
            bundle.mem_wr_en = 1'b1;
            bundle.rd_addr_a = kR8;
            bundle.rd_addr_b = reg_field(Instruction[3:1]);
        end else begin
            is_illegal = 1'b1;
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// Registered control sequencer: start/idle gate, multi-cycle load wait with
// fetch stall, sticky halt/Ack and illegal-opcode reporting.
module ctrl_seq
    import definitions::*;
#(
    parameter int RW      = 4,
    parameter int MEM_LAT = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          InstValid,
    input  logic [8:0]    Instruction,
    output logic          Stall,
    output logic          CtrlValid,
    output logic          RegWrEn,
    output logic          MemWrEn,
    output logic          MemRdEn,
    output logic          JumpEqual,
    output logic          JumpNotEqual,
    output logic          OffsetEn,
    output logic [1:0]    PCRegSelect,
    output logic [2:0]    WriteSource,
    output logic [2:0]    ALUOp,
    output logic [RW-1:0] ReadRegAddrA,
    output logic [RW-1:0] ReadRegAddrB,
    output logic [RW-1:0] WriteRegAddr,
    output logic [7:0]    ImmOut,
    output logic          Ack,
    output logic          IllegalOp,
    output logic          Busy
);

    localparam int WCW = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
    localparam logic [WCW-1:0] kWAIT_INIT = WCW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

    ctrl_state_t    state_q, state_d;
    logic [WCW-1:0] wait_q, wait_d;
    ctrl_bundle_t   bundle_q, bundle_d;
    logic           ack_q, ack_d;
    logic           illegal_q, illegal_d;

    ctrl_bundle_t   dec_bundle;
    logic           dec_illegal;
    logic           dec_halt;
    logic           dec_load;

    ctrl_decode u_decode (
        .Instruction (Instruction),
        .bundle      (dec_bundle),
        .is_illegal  (dec_illegal),
        .is_halt     (dec_halt),
        .is_load     (dec_load)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        bundle_d  = bubble(bundle_q);
        ack_d     = ack_q;
        illegal_d = illegal_q;

        case (state_q)
            IDLE: begin
                if (Start) state_d = RUN;
            end
            RUN: begin
                if (InstValid) begin
                    if (dec_halt) begin
                        state_d = HALT;
                        ack_d   = 1'b1;
                    end else if (dec_load && MEM_LAT > 0) begin
                        // Read is issued now; the write-back is held until the wait expires.
                        bundle_d            = dec_bundle;
                        bundle_d.ctrl_valid = 1'b0;
                        bundle_d.reg_wr_en  = 1'b0;
                        wait_d              = kWAIT_INIT;
                        state_d             = MEMWAIT;
                    end else begin
                        bundle_d = dec_bundle;
                        if (dec_illegal) illegal_d = 1'b1;
                    end
                end
            end
            MEMWAIT: begin
                bundle_d = bundle_q;
                if (wait_q == '0) begin
                    bundle_d.ctrl_valid = 1'b1;
                    bundle_d.reg_wr_en  = 1'b1;
                    bundle_d.mem_rd_en  = 1'b0;
                    state_d             = RUN;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            bundle_q  <= '0;
            ack_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            bundle_q  <= bundle_d;
            ack_q     <= ack_d;
            illegal_q <= illegal_d;
        end
    end

    assign Stall        = (state_q == MEMWAIT) || (state_q == HALT);
    assign Busy         = (state_q != IDLE) && (state_q != HALT);
    assign CtrlValid    = bundle_q.ctrl_valid;
    assign RegWrEn      = bundle_q.reg_wr_en;
    assign MemWrEn      = bundle_q.mem_wr_en;
    assign MemRdEn      = bundle_q.mem_rd_en;
    assign JumpEqual    = bundle_q.jump_equal;
    assign JumpNotEqual = bundle_q.jump_not_equal;
    assign OffsetEn     = bundle_q.offset_en;
    assign PCRegSelect  = bundle_q.pc_reg_select;
    assign WriteSource  = bundle_q.write_source;
    assign ALUOp        = bundle_q.alu_op;
    assign ReadRegAddrA = RW'(bundle_q.rd_addr_a);
    assign ReadRegAddrB = RW'(bundle_q.rd_addr_b);
    assign WriteRegAddr = RW'(bundle_q.wr_addr);
    assign ImmOut       = bundle_q.imm;
    assign Ack          = ack_q;
    assign IllegalOp    = illegal_q;

endmodule

// File: tb/tb_ctrl_seq.sv
// Directed bench for ctrl_seq with MEM_LAT = 2 and RW = 4.
module tb_ctrl_seq;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic       InstValid;
    logic [8:0] Instruction;
    logic       Stall, CtrlValid, RegWrEn, MemWrEn, MemRdEn;
    logic       JumpEqual, JumpNotEqual, OffsetEn;
    logic [1:0] PCRegSelect;
    logic [2:0] WriteSource, ALUOp;
    logic [3:0] ReadRegAddrA, ReadRegAddrB, WriteRegAddr;
    logic [7:0] ImmOut;
    logic       Ack, IllegalOp, Busy;

    int checks;
    int errors;

    ctrl_seq #(.RW(4), .MEM_LAT(2)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .InstValid    (InstValid),
        .Instruction  (Instruction),
        .Stall        (Stall),
        .CtrlValid    (CtrlValid),
        .RegWrEn      (RegWrEn),
        .MemWrEn      (MemWrEn),
        .MemRdEn      (MemRdEn),
        .JumpEqual    (JumpEqual),
        .JumpNotEqual (JumpNotEqual),
        .OffsetEn     (OffsetEn),
        .PCRegSelect  (PCRegSelect),
        .WriteSource  (WriteSource),
        .ALUOp        (ALUOp),
        .ReadRegAddrA (ReadRegAddrA),
        .ReadRegAddrB (ReadRegAddrB),
        .WriteRegAddr (WriteRegAddr),
        .ImmOut       (ImmOut),
        .Ack          (Ack),
        .IllegalOp    (IllegalOp),
        .Busy         (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [8:0] ins);
        Instruction = ins;
        InstValid   = 1'b1;
        step();
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        Reset       = 1'b0;
        Start       = 1'b0;
        InstValid   = 1'b0;
        Instruction = 9'h000;
        #3;
        check("rst_ctrlvalid", CtrlValid, 0);
        check("rst_stall", Stall, 0);
        check("rst_busy", Busy, 0);
        check("rst_ack", Ack, 0);
        check("rst_illegal", IllegalOp, 0);
        check("rst_wraddr", WriteRegAddr, 0);
        check("rst_regwr", RegWrEn, 0);
        step();
        Reset = 1'b1;
        step();
        check("idle_busy", Busy, 0);
        check("idle_stall", Stall, 0);

        // Valid instruction while idle is ignored
        issue(9'b1110_010_00);
        check("idle_ignore_valid", CtrlValid, 0);
        InstValid = 1'b0;

        Start = 1'b1;
        step();
        Start = 1'b0;
        check("run_busy", Busy, 1);
        check("run_ctrlvalid0", CtrlValid, 0);

        // add r2 += r8
        issue(9'b1110_010_00);
        check("add_valid", CtrlValid, 1);
        check("add_regwr", RegWrEn, 1);
        check("add_wr", WriteRegAddr, 2);
        check("add_a", ReadRegAddrA, 2);
        check("add_b", ReadRegAddrB, 8);
        check("add_op", ALUOp, 0);
        check("add_src", WriteSource, 0);

        // sub r3 -= r8
        issue(9'b1110_011_10);
        check("sub_wr", WriteRegAddr, 3);
        check("sub_op", ALUOp, 3);

        // lsl r5 = r8 << r3
        issue(9'b000_101_011);
        check("lsl_wr", WriteRegAddr, 5);
        check("lsl_a", ReadRegAddrA, 8);
        check("lsl_b", ReadRegAddrB, 3);
        check("lsl_op", ALUOp, 1);

        // lsr r1 = r8 >> r6
        issue(9'b001_001_110);
        check("lsr_op", ALUOp, 2);
        check("lsr_b", ReadRegAddrB, 6);

        InstValid = 1'b0;
        step();
        check("bubble_valid", CtrlValid, 0);
        check("bubble_regwr", RegWrEn, 0);
        check("bubble_hold_wr", WriteRegAddr, 1);

        // load r3, latency 2
        issue(9'b01000_011_0);
        InstValid = 1'b0;
        check("ld1_stall", Stall, 1);
        check("ld1_rd", MemRdEn, 1);
        check("ld1_valid", CtrlValid, 0);
        check("ld1_regwr", RegWrEn, 0);
        check("ld1_wr", WriteRegAddr, 3);
        step();
        check("ld2_stall", Stall, 1);
        check("ld2_rd", MemRdEn, 1);
        check("ld2_regwr", RegWrEn, 0);
        step();
        check("ld3_stall", Stall, 0);
        check("ld3_valid", CtrlValid, 1);
        check("ld3_regwr", RegWrEn, 1);
        check("ld3_rd", MemRdEn, 0);
        check("ld3_src", WriteSource, 1);
        check("ld3_wr", WriteRegAddr, 3);
        check("ld3_a", ReadRegAddrA, 8);

        // store r5 then je / jne back-to-back
        issue(9'b01001_101_0);
        check("st_valid", CtrlValid, 1);
        check("st_memwr", MemWrEn, 1);
        check("st_regwr", RegWrEn, 0);
        check("st_b", ReadRegAddrB, 5);
        issue(9'b1000_0_10_00);
        check("je_valid", CtrlValid, 1);
        check("je_je", JumpEqual, 1);
        check("je_jne", JumpNotEqual, 0);
        check("je_sel", PCRegSelect, 2);
        check("je_memwr", MemWrEn, 0);
        issue(9'b1000_1_01_00);
        check("jne_jne", JumpNotEqual, 1);
        check("jne_je", JumpEqual, 0);
        check("jne_sel", PCRegSelect, 1);

        // spc sel=3, offset
        issue(9'b1001_11_1_00);
        check("spc_sel", PCRegSelect, 3);
        check("spc_off", OffsetEn, 1);
        check("spc_jne", JumpNotEqual, 0);

        // mov imm 0x15
        issue(9'b1111_10101);
        check("mov_regwr", RegWrEn, 1);
        check("mov_src", WriteSource, 4);
        check("mov_wr", WriteRegAddr, 8);
        check("mov_imm", ImmOut, 8'h15);

        // or r3 |= r6
        issue(9'b1101_011_10);
        check("or_wr", WriteRegAddr, 3);
        check("or_a", ReadRegAddrA, 3);
        check("or_b", ReadRegAddrB, 6);
        check("or_op", ALUOp, 5);

        // lut high with B = r4
        issue(9'b1010_100_1_0);
        check("mlut_src", WriteSource, 3);
        check("mlut_b", ReadRegAddrB, 4);
        check("mlut_a", ReadRegAddrA, 0);

        // illegal opcode
        issue(9'b1100_00000);
        check("ill_flag", IllegalOp, 1);
        check("ill_valid", CtrlValid, 1);
        check("ill_regwr", RegWrEn, 0);
        check("ill_memwr", MemWrEn, 0);
        check("ill_op", ALUOp, 0);
        issue(9'b0110_001_00);
        check("ill_sticky", IllegalOp, 1);
        check("xor_op", ALUOp, 4);

        // halt
        issue(9'h1FF);
        check("halt_ack", Ack, 1);
        check("halt_stall", Stall, 1);
        check("halt_busy", Busy, 0);
        check("halt_valid", CtrlValid, 0);
        Start = 1'b1;
        issue(9'b1110_010_00);
        step();
        Start = 1'b0;
        check("halt_regwr", RegWrEn, 0);
        check("halt_valid2", CtrlValid, 0);
        check("halt_ack2", Ack, 1);

        // reset during MEMWAIT
        InstValid = 1'b0;
        Reset     = 1'b0;
        #2;
        Reset = 1'b1;
        step();
        Start = 1'b1;
        step();
        Start = 1'b0;
        issue(9'b01000_101_0);
        InstValid = 1'b0;
        check("rw_stall", Stall, 1);
        check("rw_rd", MemRdEn, 1);
        #2;
        Reset = 1'b0;
        #1;
        check("rw_stall0", Stall, 0);
        check("rw_rd0", MemRdEn, 0);
        check("rw_regwr0", RegWrEn, 0);
        check("rw_wr0", WriteRegAddr, 0);
        check("rw_ack0", Ack, 0);
        check("rw_ill0", IllegalOp, 0);
        check("rw_busy0", Busy, 0);
        #2;
        Reset = 1'b1;
        step();
        step();
        check("rw_idle_busy", Busy, 0);
        check("rw_idle_regwr", RegWrEn, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
